// File: rtl/rv_stream_gen_if.sv
// rtl/rv_stream_gen_if.sv - rv_if ready/valid byte stream interface
interface rv_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport egress  (output valid, output data, input  ready);
    modport ingress (input  valid, input  data, output ready);
endinterface

// File: rtl/rv_stream_gen.sv
// rtl/rv_stream_gen.sv - rv_if burst source (incrementing/LFSR data); optional RV_STREAM_GEN_THROTTLE_EN inter-beat gaps
module rv_stream_gen #(
    parameter logic [7:0] SEED  = 8'hA5,
    parameter int         LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             mode,
`ifdef RV_STREAM_GEN_THROTTLE_EN
    input  logic [7:0]       gap_thresh,
`endif
    rv_if.egress             rv_e,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] beat_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // An all-zero LFSR state would lock up, so LFSR bursts start from 1 instead.
    localparam logic [7:0] LFSR_SEED = (SEED == 8'h00) ? 8'h01 : SEED;

    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    logic [0:0]       state;
    logic             valid_q;
    logic [7:0]       data_q;
    logic [LEN_W-1:0] len_q;
    logic             mode_q;
    logic             hs;
    logic             final_beat;
    logic             gap;

`ifdef RV_STREAM_GEN_THROTTLE_EN
    logic [7:0] gap_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_lfsr <= 8'hE1;
        end else begin
            gap_lfsr <= lfsr_next(gap_lfsr);
        end
    end

    assign gap = (gap_lfsr < gap_thresh);
`else
    assign gap = 1'b0;
`endif

    assign hs         = valid_q & rv_e.ready;
    assign final_beat = (beat_cnt == len_q - LEN_W'(1));
    assign last       = valid_q & final_beat;
    assign busy       = (state == SEND);
    assign rv_e.valid = valid_q;
    assign rv_e.data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            len_q    <= '0;
            mode_q   <= 1'b0;
            done     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        beat_cnt <= '0;
                        if (len != '0) begin
                            len_q   <= len;
                            mode_q  <= mode;
                            data_q  <= mode ? LFSR_SEED : SEED;
                            valid_q <= 1'b1;
                            state   <= SEND;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        data_q   <= mode_q ? lfsr_next(data_q) : data_q + 8'd1;
                        if (final_beat) begin
                            valid_q <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            valid_q <= ~gap;
                        end
                    end else if (!valid_q) begin
                        // Inside a throttle gap: re-offer once the compare fails.
                        valid_q <= ~gap;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_stream_gen.sv
// tb/tb_rv_stream_gen.sv - directed bench for rv_stream_gen (three seeds: 10, FE, 01)
module tb_rv_stream_gen;

    localparam logic [7:0] SEEDS [3] = '{8'h10, 8'hFE, 8'h01};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st   [3];
    logic [15:0] ln   [3];
    logic        md   [3];
    logic        rdy  [3];
    logic        vld  [3];
    logic [7:0]  dat  [3];
    logic        lst  [3];
    logic        bsy  [3];
    logic        dn   [3];
    logic [15:0] bc   [3];
    logic [7:0]  gap_thresh = 8'h00;
    logic [7:0]  exp_d [8];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv_if bus ();
        assign bus.ready = rdy[g];
        assign vld[g]    = bus.valid;
        assign dat[g]    = bus.data;

        rv_stream_gen #(.SEED(SEEDS[g]), .LEN_W(16)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (st[g]),
            .len        (ln[g]),
            .mode       (md[g]),
`ifdef RV_STREAM_GEN_THROTTLE_EN
            .gap_thresh (gap_thresh),
`endif
            .rv_e       (bus),
            .last       (lst[g]),
            .busy       (bsy[g]),
            .done       (dn[g]),
            .beat_cnt   (bc[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full burst with ready held high; expected beats come from exp_d.
    task automatic run_burst(input int k, input int n, input logic m, input string tag);
        st[k] = 1'b1; ln[k] = 16'(n); md[k] = m; rdy[k] = 1'b1;
        tick();
        st[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(vld[k]), 32'd1);
            check($sformatf("%s_data%0d", tag, i), 32'(dat[k]), 32'(exp_d[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(lst[k]), 32'(i == n - 1));
            tick();
        end
        check({tag, "_done"}, 32'(dn[k]), 32'd1);
        check({tag, "_valid_off"}, 32'(vld[k]), 32'd0);
        check({tag, "_busy_off"}, 32'(bsy[k]), 32'd0);
        check({tag, "_cnt"}, 32'(bc[k]), 32'(n));
        tick();
        check({tag, "_done_once"}, 32'(dn[k]), 32'd0);
        check({tag, "_cnt_hold"}, 32'(bc[k]), 32'(n));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; ln[k] = 16'd0; md[k] = 1'b0; rdy[k] = 1'b0;
        end
        tick(); tick();
        check("rst_valid", 32'(vld[0]), 32'd0);
        check("rst_data", 32'(dat[0]), 32'd0);
        check("rst_last", 32'(lst[0]), 32'd0);
        check("rst_busy", 32'(bsy[0]), 32'd0);
        check("rst_done", 32'(dn[0]), 32'd0);
        check("rst_cnt", 32'(bc[0]), 32'd0);
        rst = 1'b0;
        tick();

        exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(0, 4, 1'b0, "basic");
        exp_d = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(1, 4, 1'b0, "wrap");
        exp_d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h00, 8'h00, 8'h00};
        run_burst(2, 5, 1'b1, "lfsr");

        // Backpressure on beat 1
        st[0] = 1'b1; ln[0] = 16'd3; md[0] = 1'b0; rdy[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        check("bp_data0", 32'(dat[0]), 32'h10);
        tick();
        rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_hold_valid%0d", i), 32'(vld[0]), 32'd1);
            check($sformatf("bp_hold_data%0d", i), 32'(dat[0]), 32'h11);
            check($sformatf("bp_hold_last%0d", i), 32'(lst[0]), 32'd0);
            tick();
        end
        rdy[0] = 1'b1;
        check("bp_data1", 32'(dat[0]), 32'h11);
        tick();
        check("bp_data2", 32'(dat[0]), 32'h12);
        check("bp_last2", 32'(lst[0]), 32'd1);
        tick();
        check("bp_done", 32'(dn[0]), 32'd1);
        check("bp_cnt", 32'(bc[0]), 32'd3);
        tick();

        // Zero-length burst
        st[0] = 1'b1; ln[0] = 16'd0;
        tick();
        st[0] = 1'b0;
        check("len0_valid", 32'(vld[0]), 32'd0);
        check("len0_done", 32'(dn[0]), 32'd1);
        check("len0_busy", 32'(bsy[0]), 32'd0);
        check("len0_cnt", 32'(bc[0]), 32'd0);
        tick();
        check("len0_done_once", 32'(dn[0]), 32'd0);
        check("len0_valid2", 32'(vld[0]), 32'd0);

        // Start while busy is ignored
        st[0] = 1'b1; ln[0] = 16'd4; md[0] = 1'b0;
        tick();
        st[0] = 1'b0;
        check("busy_data0", 32'(dat[0]), 32'h10);
        tick();
        check("busy_data1", 32'(dat[0]), 32'h11);
        st[0] = 1'b1; ln[0] = 16'd2; md[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        check("busy_data2", 32'(dat[0]), 32'h12);
        check("busy_last2", 32'(lst[0]), 32'd0);
        tick();
        check("busy_data3", 32'(dat[0]), 32'h13);
        check("busy_last3", 32'(lst[0]), 32'd1);
        tick();
        check("busy_done", 32'(dn[0]), 32'd1);
        check("busy_cnt", 32'(bc[0]), 32'd4);
        tick();

        // Start in the done cycle
        st[0] = 1'b1; ln[0] = 16'd2; md[0] = 1'b0;
        tick();
        st[0] = 1'b0;
        tick();
        check("b2b_last", 32'(lst[0]), 32'd1);
        tick();
        check("b2b_done", 32'(dn[0]), 32'd1);
        check("b2b_gap_valid", 32'(vld[0]), 32'd0);
        st[0] = 1'b1; ln[0] = 16'd2;
        tick();
        st[0] = 1'b0;
        check("b2b_valid2", 32'(vld[0]), 32'd1);
        check("b2b_data2", 32'(dat[0]), 32'h10);
        tick(); tick();
        check("b2b_done2", 32'(dn[0]), 32'd1);
        tick();

        // Reset mid-burst
        st[0] = 1'b1; ln[0] = 16'd6; md[0] = 1'b0;
        tick();
        st[0] = 1'b0;
        tick(); tick();
        check("mid_cnt", 32'(bc[0]), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("mid_valid", 32'(vld[0]), 32'd0);
        check("mid_busy", 32'(bsy[0]), 32'd0);
        check("mid_cnt0", 32'(bc[0]), 32'd0);
        check("mid_done", 32'(dn[0]), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_no_done", 32'(dn[0]), 32'd0);
        exp_d = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_burst(0, 1, 1'b0, "post_rst");

`ifdef RV_STREAM_GEN_THROTTLE_EN
        begin
            int idx  = 0;
            int gaps = 0;
            logic pv = 1'b0;
            logic pr = 1'b0;
            logic [7:0] pd = 8'h00;
            gap_thresh = 8'h80;
            st[0] = 1'b1; ln[0] = 16'd32; md[0] = 1'b0; rdy[0] = 1'b0;
            tick();
            st[0] = 1'b0;
            for (int c = 0; c < 2000 && idx < 32; c++) begin
                if (pv && !pr) begin
                    check("thr_no_withdraw", 32'(vld[0]), 32'd1);
                    check("thr_stable", 32'(dat[0]), 32'(pd));
                end
                if (!vld[0] && bsy[0] && idx > 0) gaps++;
                rdy[0] = 1'($urandom_range(0, 1));
                if (vld[0] && rdy[0]) begin
                    check($sformatf("thr_data%0d", idx), 32'(dat[0]), 32'(8'h10 + 8'(idx)));
                    check($sformatf("thr_last%0d", idx), 32'(lst[0]), 32'(idx == 31));
                    idx++;
                end
                pv = vld[0]; pr = rdy[0]; pd = dat[0];
                tick();
            end
            check("thr_all_beats", 32'(idx), 32'd32);
            check("thr_done", 32'(dn[0]), 32'd1);
            check("thr_gaps_seen", 32'(gaps > 0), 32'd1);
            gap_thresh = 8'h00;
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
